micro_sequencer: RTL and testbench



---
 rtl/micro_sequencer_if.sv | 27 ++
 rtl/micro_sequencer.sv | 117 +++++++++++
 tb/tb_micro_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/micro_sequencer_if.sv
// Bus between the micro-sequencer and its control-unit neighbours.
// The master is the sequencer. The slave is the ROM/datapath side.
interface micro_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int CW_W   = 37,
  parameter int CNT_W  = 16
);
  logic [CW_W-1:0]   ctrl_word;
  logic [3:0]        opcode;
  logic              z_flag;
  logic              stall;
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic              halted;
  logic              illegal;
  logic [CNT_W-1:0]  instr_count;

  modport master (
    input  ctrl_word, opcode, z_flag, stall, start,
    output rom_addr, halted, illegal, instr_count
  );

  modport slave (
    output ctrl_word, opcode, z_flag, stall, start,
    input  rom_addr, halted, illegal, instr_count
  );
endinterface

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the micro-PC and picks the next ROM address
// from the control word's mode/next fields, the opcode and the Z flag.
module micro_sequencer #(
  parameter int ADDR_W = 5,
  parameter int CW_W   = 37,
  parameter int CNT_W  = 16
) (
  input logic                clk,
  input logic                rst_n,
  micro_sequencer_if.master  bus
);

  typedef enum logic [1:0] {
    M_JUMP     = 2'b00,
    M_DISPATCH = 2'b01,
    M_INC      = 2'b10,
    M_HALT     = 2'b11
  } mode_e;

  typedef enum logic {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] upc;
  logic              halted_q;
  logic              illegal_q;
  logic [CNT_W-1:0]  count_q;

  mode_e             mode;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_stop;
  logic              disp_bad;

  assign mode      = mode_e'(bus.ctrl_word[6:5]);
  assign next_addr = bus.ctrl_word[ADDR_W-1:0];

  // The sequencer decodes only the low seven bits of the word.
  // The remaining bits drive the datapath.
  wire unused_cw_bits = ^bus.ctrl_word[CW_W-1:7];

  // NOTE: every output of this block gets a default before the case. If any
  // path left one of them unassigned, synthesis would infer a latch.
  always_comb begin
    disp_addr = '0;
    disp_stop = 1'b1;
    disp_bad  = 1'b1;
    unique case (bus.opcode)
      4'd0:  begin disp_addr = ADDR_W'(0);  disp_stop = 1'b0; disp_bad = 1'b0; end
      4'd1:  begin disp_addr = ADDR_W'(21); disp_stop = 1'b0; disp_bad = 1'b0; end
      4'd2:  begin disp_addr = ADDR_W'(24); disp_stop = 1'b0; disp_bad = 1'b0; end
      4'd3:  begin disp_addr = ADDR_W'(18); disp_stop = 1'b0; disp_bad = 1'b0; end
      4'd4:  begin
        disp_addr = bus.z_flag ? ADDR_W'(13) : ADDR_W'(10);
        disp_stop = 1'b0;
        disp_bad  = 1'b0;
      end
      4'd15: disp_bad = 1'b0;
      default: ;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments. Every register
  // then sees the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RUN;
      upc       <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      unique case (state)
        S_RUN: begin
          if (!bus.stall) begin
            unique case (mode)
              M_JUMP: upc <= next_addr;
              M_DISPATCH: begin
                count_q <= count_q + 1'b1;
                if (disp_stop) begin
                  upc       <= '0;
                  halted_q  <= 1'b1;
                  illegal_q <= disp_bad;
                  state     <= S_HALT;
                end else begin
                  upc <= disp_addr;
                end
              end
              M_INC: upc <= upc + 1'b1;
              M_HALT: begin
                halted_q <= 1'b1;
                state    <= S_HALT;
              end
            endcase
          end
        end
        S_HALT: begin
          // Stall is deliberately not checked here, so start always restarts the sequencer.
          if (bus.start) begin
            upc       <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            state     <= S_RUN;
          end
        end
      endcase
    end
  end

  assign bus.rom_addr    = upc;
  assign bus.halted      = halted_q;
  assign bus.illegal     = illegal_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Scoreboard bench for micro_sequencer: directed scenarios, then random stimulus,
// then counter wrap, all checked against a behavioural model.
module tb_micro_sequencer;

  localparam logic [1:0] JUMP = 2'b00, DISP = 2'b01, INC = 2'b10, HALT = 2'b11;

  logic clk = 1'b0;
  logic rst_n;

  micro_sequencer_if #(.ADDR_W(5), .CW_W(37), .CNT_W(16)) bus ();

  micro_sequencer #(.ADDR_W(5), .CW_W(37), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    addr;
    bit    halted;
    bit    illegal;
    int    cnt;
    string name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int m_upc, m_cnt;
  bit m_halted, m_illegal;
  int disp_tab[16];  // >=0 target, -1 illegal, -2 halt opcode

  // One cycle: drive the inputs and advance the model. Then queue the state
  // the DUT must show after the next rising edge.
  task automatic step(input logic [1:0] mode, input int nxt, input int op,
                      input bit z, input bit stl, input bit st, input bit rst,
                      input string name);
    logic [36:0] w;
    exp_t        e;
    int          d;
    @(negedge clk);
    w       = 37'({$urandom(), $urandom()});
    w[6:5]  = mode;
    w[4:0]  = 5'(nxt);
    bus.ctrl_word = w;
    bus.opcode    = 4'(op);
    bus.z_flag    = z;
    bus.stall     = stl;
    bus.start     = st;
    rst_n         = ~rst;

    if (rst) begin
      m_upc = 0; m_cnt = 0; m_halted = 0; m_illegal = 0;
    end else if (m_halted) begin
      if (st) begin m_upc = 0; m_halted = 0; m_illegal = 0; end
    end else if (!stl) begin
      case (mode)
        JUMP: m_upc = nxt % 32;
        INC:  m_upc = (m_upc + 1) % 32;
        HALT: m_halted = 1;
        default: begin
          m_cnt = (m_cnt + 1) % 65536;
          d = (op == 4) ? (z ? 13 : 10) : disp_tab[op];
          if (d < 0) begin
            m_upc = 0;
            m_halted = 1;
            if (d == -1) m_illegal = 1;
          end else begin
            m_upc = d;
          end
        end
      endcase
    end
    e.addr = m_upc; e.halted = m_halted; e.illegal = m_illegal;
    e.cnt = m_cnt; e.name = name;
    q.push_back(e);
  endtask

  // Monitor: one queued expectation per rising edge, sampled just after it
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus.rom_addr !== 5'(e.addr) || bus.halted !== e.halted ||
            bus.illegal !== e.illegal || bus.instr_count !== 16'(e.cnt)) begin
          n_bad++;
          $display("FAIL %s: got addr=%0d halted=%0b illegal=%0b cnt=%0d, want addr=%0d halted=%0b illegal=%0b cnt=%0d",
                   e.name, bus.rom_addr, bus.halted, bus.illegal, bus.instr_count,
                   e.addr, e.halted, e.illegal, e.cnt);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    bus.ctrl_word = '0; bus.opcode = '0; bus.z_flag = 1'b0;
    bus.stall = 1'b0; bus.start = 1'b0;
    m_upc = 0; m_cnt = 0; m_halted = 0; m_illegal = 0;
    for (int i = 0; i < 16; i++) disp_tab[i] = -1;
    disp_tab[0] = 0; disp_tab[1] = 21; disp_tab[2] = 24; disp_tab[3] = 18;
    disp_tab[15] = -2;

    // Reset and release
    step(JUMP, 7, 0, 0, 0, 0, 1, "reset1");
    step(JUMP, 7, 0, 0, 0, 0, 1, "reset2");
    step(JUMP, 7, 0, 0, 0, 0, 0, "release_jump7");

    // Jump, then increment with wrap
    step(JUMP, 1, 0, 0, 0, 0, 0, "jump1");
    step(JUMP, 31, 0, 0, 0, 0, 0, "jump31");
    step(INC, 0, 0, 0, 0, 0, 0, "inc_wrap");
    step(INC, 0, 0, 0, 0, 1, 0, "inc_start_ignored");

    // Dispatch table
    step(DISP, 0, 1, 0, 0, 0, 0, "disp_load");
    step(DISP, 0, 2, 1, 0, 0, 0, "disp_store");
    step(DISP, 0, 3, 0, 0, 0, 0, "disp_mul");
    step(DISP, 0, 4, 0, 0, 0, 0, "disp_jmpnz_z0");
    step(DISP, 0, 4, 1, 0, 0, 0, "disp_jmpnz_z1");
    step(DISP, 0, 0, 1, 0, 0, 0, "disp_nop");

    // Stall holds everything mid-INC
    step(JUMP, 5, 0, 0, 0, 0, 0, "jump5");
    for (int i = 0; i < 3; i++) step(INC, 0, 0, 0, 1, 0, 0, "stall_inc");
    step(DISP, 0, 1, 0, 1, 0, 0, "stall_disp");
    step(INC, 0, 0, 0, 0, 0, 0, "unstall_inc");

    // Illegal dispatch, frozen halt, restart
    step(DISP, 0, 9, 0, 0, 0, 0, "disp_illegal");
    for (int i = 0; i < 4; i++)
      step(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), 1, 0, i[0], 0, 0, "halt_frozen");
    step(JUMP, 3, 0, 0, 1, 1, 0, "start_with_stall");

    // HALT opcode, HALT word, reset beats start
    step(DISP, 0, 15, 0, 0, 0, 0, "disp_halt_op");
    step(JUMP, 9, 0, 0, 0, 1, 0, "start_after_halt_op");
    step(JUMP, 12, 0, 0, 0, 0, 0, "jump12");
    step(HALT, 3, 0, 0, 0, 0, 0, "halt_word");
    step(INC, 0, 0, 0, 0, 0, 0, "halt_word_hold");
    step(JUMP, 4, 0, 0, 0, 1, 1, "reset_beats_start");

    // Random stimulus
    for (int i = 0; i < 600; i++)
      step(2'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 49) == 0), "random");

    // Counter wrap through real dispatches
    step(JUMP, 0, 0, 0, 0, 0, 1, "pre_wrap_reset");
    while (m_cnt != 65535)
      step(DISP, 0, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), 0, 0, 0, "count_up");
    step(DISP, 0, 2, 0, 0, 0, 0, "count_wrap");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
